// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RISC-V instruction-fetch stage. Owns the PC, fetches one 32-bit
//            instruction at a time over a req/gnt/rvalid instruction-memory
//            port, and presents instruction, PC and PC+4 to decode. Applies
//            execute-stage redirects and discards fetches made stale by them.
// Ports    : clk, reset (async, active-low)
//            StallF, PCSrcE, PCTargetE          - hazard / redirect controls
//            imem_req_o, imem_addr_o            - fetch request
//            imem_gnt_i, imem_rvalid_i,
//            imem_rdata_i                       - memory grant / response
//            instr_o, pcf_o, pc_plus_o,
//            instr_valid_o, fetch_busy_o        - to decode / hazard unit
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcf_o,
  output logic [31:0] pc_plus_o,
  output logic        instr_valid_o,
  output logic        fetch_busy_o
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        kill_q, kill_d;
  // Low for the first cycle after reset release so that no request is issued
  // (and no grant accepted) before the first rising edge out of reset.
  logic        live_q, live_d;

  logic [31:0] redirect_pc;
  logic        req_live;
  logic        granted;
  logic        unused_target_lsbs;

  assign redirect_pc        = {PCTargetE[31:2], 2'b00};
  assign unused_target_lsbs = ^PCTargetE[1:0];
  assign req_live           = (state_q == S_REQ) && live_q;
  assign granted            = req_live && imem_gnt_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (granted) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A redirect arriving with the response makes it stale just like kill.
        if (imem_rvalid_i) state_d = (kill_q || PCSrcE) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (PCSrcE || !StallF) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: PC, held instruction, kill flag, live flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      kill_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      kill_q  <= kill_d;
      live_q  <= live_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    kill_d  = kill_q;
    live_d  = 1'b1;

    // Redirect wins over both the stall and the normal sequential advance.
    if (PCSrcE) begin
      pc_d = redirect_pc;
    end else if ((state_q == S_HOLD) && !StallF) begin
      pc_d = pc_q + 32'd4;
    end

    unique case (state_q)
      S_REQ: begin
        // Granted in the redirect cycle: the response will be for the old PC.
        if (granted) kill_d = PCSrcE;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (!kill_q && !PCSrcE) instr_d = imem_rdata_i;
        end else if (PCSrcE) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE) instr_d = NOP_INSTR;
      end
      default: begin
        kill_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req_o    = req_live;
    imem_addr_o   = pc_q;
    pcf_o         = pc_q;
    pc_plus_o     = pc_q + 32'd4;
    instr_valid_o = (state_q == S_HOLD);
    instr_o       = (state_q == S_HOLD) ? instr_q : NOP_INSTR;
    fetch_busy_o  = (state_q != S_HOLD);
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. Directed stimulus pushes
//            hand-computed expected instructions into a scoreboard queue; a
//            monitor pops and compares whenever the DUT presents a new valid
//            instruction. A small memory model answers grants after a
//            programmable latency with data = addr ^ 32'hA5A5_0000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pcf_o;
  logic [31:0] pc_plus_o;
  logic        instr_valid_o;
  logic        fetch_busy_o;

  logic        gnt_en;
  int          lat;
  int          checks;
  int          failures;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .pcf_o        (pcf_o),
    .pc_plus_o    (pc_plus_o),
    .instr_valid_o(instr_valid_o),
    .fetch_busy_o (fetch_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_gnt_i = imem_req_o & gnt_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: one outstanding fetch, response 'lat' cycles after grant.
  initial begin
    int          mem_wait;
    logic [31:0] mem_addr;
    mem_wait      = 0;
    mem_addr      = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (imem_req_o && imem_gnt_i) begin
        mem_wait = lat;
        mem_addr = imem_addr_o;
      end
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (mem_wait > 0) begin
        mem_wait--;
        if (mem_wait == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_addr ^ 32'hA5A5_0000;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic held;
    exp_t cur;
    held = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (instr_valid_o) begin
        if (held) begin
          chk("held_instr", instr_o, cur.instr);
          chk("held_pcf", pcf_o, cur.pc);
          chk("held_no_req", {31'd0, imem_req_o}, 32'd0);
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got %h at pc %h expected none", instr_o, pcf_o);
        end else begin
          cur = exp_q.pop_front();
          chk("sb_instr", instr_o, cur.instr);
          chk("sb_pcf", pcf_o, cur.pc);
          chk("sb_pc_plus", pc_plus_o, cur.pc + 32'd4);
        end
        held = StallF && !PCSrcE;
      end else begin
        chk("bubble_nop", instr_o, NOP);
        held = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int exp_n, input string nm);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!instr_valid_o && n < 30);
    chk(nm, n, exp_n);
  endtask

  task automatic wait_req(input int exp_n, input logic [31:0] exp_addr, input string nm);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!imem_req_o && n < 30);
    chk({nm, "_lat"}, n, exp_n);
    chk({nm, "_addr"}, imem_addr_o, exp_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    StallF    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = '0;
    gnt_en    = 1'b1;
    lat       = 1;
    #2 reset  = 1'b0;
    step(2);

    // Reset values
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pcf", pcf_o, 32'h0000_0100);
    chk("rst_pc_plus", pc_plus_o, 32'h0000_0104);
    chk("rst_busy", {31'd0, fetch_busy_o}, 32'd1);

    // Zero-wait sequential fetch
    exp_q.push_back('{instr: 32'hA5A5_0100, pc: 32'h0000_0100});
    exp_q.push_back('{instr: 32'hA5A5_0104, pc: 32'h0000_0104});
    reset = 1'b1;
    chk("no_req_before_edge", {31'd0, imem_req_o}, 32'd0);
    step(1);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'h0000_0100);
    wait_valid(2, "first_valid_lat");
    wait_valid(3, "second_valid_lat");

    // Stall in HOLD for 5 cycles
    StallF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("stall_pc_plus", pc_plus_o, 32'h0000_0108);
      chk("stall_busy", {31'd0, fetch_busy_o}, 32'd0);
    end
    StallF = 1'b0;
    lat    = 4;
    step(1);
    chk("post_stall_req", {31'd0, imem_req_o}, 32'd1);
    chk("post_stall_addr", imem_addr_o, 32'h0000_0108);

    // Redirect while WAIT, response delayed
    exp_q.push_back('{instr: 32'hA5A5_2000, pc: 32'h0000_2000});
    step(1);
    chk("wait_busy", {31'd0, fetch_busy_o}, 32'd1);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_2003;
    step(1);
    PCSrcE = 1'b0;
    lat    = 1;
    wait_req(3, 32'h0000_2000, "wait_redirect");
    wait_valid(2, "wait_redirect_valid");

    // Redirect in the same cycle as a grant
    exp_q.push_back('{instr: 32'hA5A5_3000, pc: 32'h0000_3000});
    step(1);
    chk("gnt_redirect_addr_old", imem_addr_o, 32'h0000_2004);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_3000;
    step(1);
    PCSrcE = 1'b0;
    chk("gnt_redirect_wait_req", {31'd0, imem_req_o}, 32'd0);
    step(1);
    chk("gnt_redirect_req", {31'd0, imem_req_o}, 32'd1);
    chk("gnt_redirect_addr", imem_addr_o, 32'h0000_3000);
    wait_valid(2, "gnt_redirect_valid");

    // Redirect from HOLD to top of address space, then wrap
    exp_q.push_back('{instr: 32'h5A5A_FFFC, pc: 32'hFFFF_FFFC});
    exp_q.push_back('{instr: 32'hA5A5_0000, pc: 32'h0000_0000});
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFE;
    step(1);
    PCSrcE = 1'b0;
    chk("hold_redirect_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("hold_redirect_addr", imem_addr_o, 32'hFFFF_FFFC);
    wait_valid(2, "wrap_valid");
    chk("wrap_pc_plus", pc_plus_o, 32'h0000_0000);
    step(1);
    chk("wrap_addr", imem_addr_o, 32'h0000_0000);
    wait_valid(2, "zero_valid");

    // Asynchronous reset mid-WAIT, late response must be ignored
    lat = 3;
    step(1);
    chk("pre_reset_addr", imem_addr_o, 32'h0000_0004);
    step(1);
    #1;
    reset  = 1'b0;
    gnt_en = 1'b0;
    #1;
    chk("async_rst_pcf", pcf_o, 32'h0000_0100);
    chk("async_rst_pc_plus", pc_plus_o, 32'h0000_0104);
    chk("async_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("async_rst_busy", {31'd0, fetch_busy_o}, 32'd1);
    step(1);
    reset = 1'b1;
    chk("rel_req", {31'd0, imem_req_o}, 32'd0);
    step(1);
    chk("late_rvalid_req", {31'd0, imem_req_o}, 32'd1);
    chk("late_rvalid_addr", imem_addr_o, 32'h0000_0100);
    step(1);
    chk("late_rvalid_ignored", {31'd0, instr_valid_o}, 32'd0);
    exp_q.push_back('{instr: 32'hA5A5_0100, pc: 32'h0000_0100});
    lat    = 1;
    gnt_en = 1'b1;
    wait_valid(2, "restart_valid");
    step(1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
